// File: rtl/uart_cmd_assembler_pkg.sv
// rtl/uart_cmd_assembler_pkg.sv - shared types, defaults and width helper for the command assembler
package uart_cmd_pkg;

  typedef enum logic {IDLE, COLLECT} asm_state_t;

  localparam int CMD_BYTES_DEF = 3;
  localparam int GAP_CYC_DEF   = 20000;

  function automatic int cmd_w(input int n);
    return 8 * n;
  endfunction

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// rtl/uart_cmd_assembler_if.sv - byte-in / command-out handshake bundle for the command assembler
interface uart_cmd_assembler_if
  import uart_cmd_pkg::*;
#(
  parameter int CMD_BYTES = CMD_BYTES_DEF
);

  logic [7:0]                  rx_data;
  logic                        rx_rdy;
  logic                        clr_rx_rdy;
  logic [cmd_w(CMD_BYTES)-1:0] cmd;
  logic                        cmd_rdy;
  logic                        clr_cmd_rdy;
  logic                        overrun;
  logic                        gap_err;

  modport master (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, overrun, gap_err
  );

  modport slave (
    output rx_data, rx_rdy, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, overrun, gap_err
  );

endinterface

// File: rtl/uart_cmd_assembler_gap_timer.sv
// rtl/uart_cmd_assembler_gap_timer.sv - saturating inter-byte gap counter with expiry flag
module gap_timer #(
  parameter int GAP_CYC = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int           W     = $clog2(GAP_CYC);
  localparam logic [W-1:0] LIMIT = W'(GAP_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  // A clear in the same cycle is an accepted byte, which must beat the timeout.
  assign expire = en && !clr && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - packs received UART bytes MSB-first into command words with gap timeout
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int CMD_BYTES = CMD_BYTES_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_cmd_assembler_if.master  bus
);

  localparam int CW = cmd_w(CMD_BYTES);

  asm_state_t    state, state_nx;
  logic [2:0]    byte_cnt, byte_cnt_nx;
  logic [CW-1:0] asm_q, asm_shift, cmd_q;
  logic          clr_rx_q, cmd_rdy_q, overrun_q, gap_err_q;
  logic          accept, last_byte, expire, gap_fire;

  // Gating on our own pending ack avoids re-capturing the byte before the receiver drops rdy.
  assign accept    = bus.rx_rdy && !clr_rx_q;
  assign asm_shift = {asm_q[CW-9:0], bus.rx_data};
  assign last_byte = accept && (state == COLLECT) && (byte_cnt == 3'(CMD_BYTES - 1));

  gap_timer #(
    .GAP_CYC (GAP_CYC)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept || (state == IDLE)),
    .en     (state == COLLECT),
    .expire (expire)
  );

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    gap_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          byte_cnt_nx = 3'd1;
          state_nx    = COLLECT;
        end
      end
      COLLECT: begin
        if (last_byte) begin
          byte_cnt_nx = 3'd0;
          state_nx    = IDLE;
        end else if (accept) begin
          byte_cnt_nx = byte_cnt + 3'd1;
        end else if (expire) begin
          byte_cnt_nx = 3'd0;
          gap_fire    = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: begin
        byte_cnt_nx = 3'd0;
        state_nx    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= 3'd0;
      asm_q     <= '0;
      cmd_q     <= '0;
      clr_rx_q  <= 1'b0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      gap_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      byte_cnt  <= byte_cnt_nx;
      clr_rx_q  <= accept;
      gap_err_q <= gap_fire;
      if (accept) begin
        asm_q <= asm_shift;
      end
      if (last_byte && (!cmd_rdy_q || bus.clr_cmd_rdy)) begin
        cmd_q     <= asm_shift;
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
      if (bus.clr_cmd_rdy) begin
        overrun_q <= 1'b0;
      end else if (last_byte && cmd_rdy_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.clr_rx_rdy = clr_rx_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.overrun    = overrun_q;
  assign bus.gap_err    = gap_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - directed scoreboard bench for the UART command assembler
module tb_uart_cmd_assembler;

  localparam int NB  = 3;
  localparam int GAP = 50;

  logic clk = 1'b0;
  logic rst_n;

  uart_cmd_assembler_if #(.CMD_BYTES(NB)) bus ();

  uart_cmd_assembler #(
    .CMD_BYTES (NB),
    .GAP_CYC   (GAP)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int clr_high = 0;
  int gap_pulses = 0;
  int nbytes = 0;

  logic [8*NB+1:0] exp_q[$];
  logic [8*NB-1:0] m_cmd = '0;
  logic            m_rdy = 1'b0;
  logic            m_ovr = 1'b0;

  always @(negedge clk) begin
    if (bus.clr_rx_rdy === 1'b1) clr_high++;
    if (bus.gap_err === 1'b1) gap_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.clr_rx_rdy === 1'b1) seen = 1'b1;
    end
    check({tag, "_ack"}, 32'(seen), 32'd1);
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr_last, input string tag);
    @(negedge clk);
    bus.rx_data     = b;
    bus.rx_rdy      = 1'b1;
    bus.clr_cmd_rdy = clr_last;
    wait_ack(tag);
    nbytes++;
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic clr_last, input logic pre, input string tag);
    logic [8*NB+1:0] e;
    if (!m_rdy || clr_last) begin
      m_cmd = {b0, b1, b2};
      m_rdy = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
    if (clr_last) m_ovr = 1'b0;
    exp_q.push_back({m_cmd, m_rdy, m_ovr});
    if (pre) begin
      wait_ack(tag);
      nbytes++;
    end else begin
      send_byte(b0, 1'b0, tag);
    end
    idle(10);
    send_byte(b1, 1'b0, tag);
    idle(10);
    send_byte(b2, clr_last, tag);
    e = exp_q.pop_front();
    check({tag, "_cmd"}, 32'(bus.cmd), 32'(e[8*NB+1:2]));
    check({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'(e[1]));
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(e[0]));
    idle(2);
    check({tag, "_clr_pulses"}, 32'(clr_high), 32'(nbytes));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd"}, 32'(bus.cmd), 32'd0);
    check({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    check({tag, "_clr_rx_rdy"}, 32'(bus.clr_rx_rdy), 32'd0);
    check({tag, "_gap_err"}, 32'(bus.gap_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int gap_before;
    rst_n           = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;

    idle(3);
    check_zero("in_reset");
    rst_n = 1'b1;
    idle(5);
    check_zero("post_reset");
    check("post_reset_no_ack", 32'(clr_high), 32'd0);

    send_cmd(8'hA5, 8'h3C, 8'h0F, 1'b0, 1'b0, "cmd1");

    send_cmd(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, "ovr");
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    check("clr_cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
    check("clr_overrun", 32'(bus.overrun), 32'(m_ovr));
    check("clr_cmd_hold", 32'(bus.cmd), 32'(m_cmd));

    send_byte(8'h01, 1'b0, "gap1");
    idle(10);
    send_byte(8'h02, 1'b0, "gap2");
    gap_before = gap_pulses;
    at = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.gap_err === 1'b1 && at == 0) at = i;
    end
    check("gap_latency", 32'(at), 32'(GAP));
    check("gap_once", 32'(gap_pulses - gap_before), 32'd1);
    check("gap_clr_pulses", 32'(clr_high), 32'(nbytes));

    send_cmd(8'hDE, 8'hAD, 8'hBE, 1'b0, 1'b0, "after_gap");

    send_cmd(8'h44, 8'h55, 8'h66, 1'b1, 1'b0, "same_clr");

    send_byte(8'h77, 1'b0, "stale");
    idle(3);
    @(negedge clk);
    bus.rx_data = 8'h88;
    bus.rx_rdy  = 1'b1;
    rst_n       = 1'b0;
    #1;
    check_zero("async_reset");
    m_cmd = '0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(8'h88, 8'h99, 8'hAA, 1'b0, 1'b1, "rst");

    check("gap_total", 32'(gap_pulses), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
